// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: OTTER IF stage (PC, single-outstanding imem fetch, instr FIFO); FETCH_PERF_CNT_EN adds REDIR_CNT
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REDIR_VALID,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] REDIR_CNT,
`endif
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  input  logic        IF_READY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, tag_q, tag_d, target;
  logic live_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, occ;
  logic [31:0] fpc_q [FIFO_DEPTH];
  logic [31:0] fpc_d [FIFO_DEPTH];
  logic [31:0] fins_q [FIFO_DEPTH];
  logic [31:0] fins_d [FIFO_DEPTH];
  logic redirect, busy, push, pop, req, gnt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
`endif
  always_comb begin
    redirect = REDIR_VALID & (PC_SOURCE inside {3'd1, 3'd2, 3'd3});
    target = (PC_SOURCE == 3'd1 ? JALR_TGT : PC_SOURCE == 3'd2 ? BRANCH_TGT : JAL_TGT) & ~32'h3;
    busy = state_q != S_RUN;
    IF_VALID = RST_N & (cnt_q != '0);
    pop = IF_VALID & IF_READY;
    push = (state_q == S_WAIT) & IMEM_RVALID & ~redirect;
    // a completing response turns its outstanding slot into an occupied one, so busy covers both
    occ = cnt_q + CW'(busy) - CW'(pop);
    req = RST_N & live_q & ~redirect & ((state_q == S_RUN) | ((state_q == S_WAIT) & IMEM_RVALID))
          & (occ < CW'(FIFO_DEPTH));
    gnt = req & IMEM_GNT;
    state_d = redirect ? ((busy & ~IMEM_RVALID) ? S_DROP : S_RUN)
            : gnt ? S_WAIT
            : (busy & IMEM_RVALID) ? S_RUN : state_q;
    pc_d = redirect ? target : gnt ? pc_q + 32'd4 : pc_q;
    tag_d = gnt ? pc_q : tag_q;
    wr_d = redirect ? '0 : wr_q + AW'(push);
    rd_d = redirect ? '0 : rd_q + AW'(pop);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    fpc_d = fpc_q;
    fins_d = fins_q;
    if (push) begin
      fpc_d[wr_q] = tag_q;
      fins_d[wr_q] = IMEM_RDATA;
    end
`ifdef FETCH_PERF_CNT_EN
    redir_cnt_d = redir_cnt_q + 32'(redirect);
`endif
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_RUN;
      pc_q <= RESET_VEC;
      tag_q <= '0;
      live_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
`ifdef FETCH_PERF_CNT_EN
      redir_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tag_q <= tag_d;
      live_q <= 1'b1;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
`ifdef FETCH_PERF_CNT_EN
      redir_cnt_q <= redir_cnt_d;
`endif
    end
    fpc_q <= fpc_d;
    fins_q <= fins_d;
  end
  assign IMEM_REQ = req;
  assign IMEM_ADDR = pc_q;
  assign IF_PC = IF_VALID ? fpc_q[rd_q] : '0;
  assign IF_INSTR = IF_VALID ? fins_q[rd_q] : '0;
`ifdef FETCH_PERF_CNT_EN
  assign REDIR_CNT = redir_cnt_q;
`endif
endmodule
